// File: rtl/instr_fetch_pkg.sv
// Shared constants for the instruction fetch unit:
// PC source select and fetch FSM state encodings.
package instr_fetch_pkg;

  localparam logic PC_SRC_PLUS_4   = 1'b0;
  localparam logic PC_SRC_PLUS_OFF = 1'b1;

  localparam logic [1:0] FETCH_ST_IDLE  = 2'd0;
  localparam logic [1:0] FETCH_ST_FETCH = 2'd1;
  localparam logic [1:0] FETCH_ST_VALID = 2'd2;
  localparam logic [1:0] FETCH_ST_ERR   = 2'd3;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC arithmetic: sequential and offset targets,
// plus the misalignment flag of the selected target.
module fetch_pc_next
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pc_src,
  input  logic [31:0] pc_off,
  output logic [31:0] pc_next,
  output logic [31:0] pc_plus_4,
  output logic        misalign
);

  logic [31:0] pc_tgt;

  // Both candidates wrap modulo 2^32 by construction.
  always_comb begin
    pc_plus_4 = pc + 32'd4;
    pc_tgt    = pc + pc_off;
    pc_next   = (pc_src == PC_SRC_PLUS_OFF) ? pc_tgt
                                            : pc_plus_4;
    misalign  = |pc_next[1:0];
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, fetches over req/ack,
// holds instr until commit, flags timeout and misalignment.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  input  logic        commit,
  input  logic        pc_src,
  input  logic [31:0] pc_off,
  output logic        fetch_err,
  output logic        misalign
);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;

  logic [31:0] pc_next;
  logic        tgt_mis;
  logic [7:0]  cnt_inc;

  fetch_pc_next u_pc_next (
    .pc        (pc_q),
    .pc_src    (pc_src),
    .pc_off    (pc_off),
    .pc_next   (pc_next),
    .pc_plus_4 (pc_plus_4),
    .misalign  (tgt_mis)
  );

  // FSM next-state: fetch, hold until commit, trap on error.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mis_d   = mis_q;
    cnt_inc = cnt_q + 8'd1;
    unique case (state_q)
      FETCH_ST_IDLE: begin
        state_d = FETCH_ST_FETCH;
      end
      FETCH_ST_FETCH: begin
        if (mem_ack) begin
          instr_d = mem_rdata;
          cnt_d   = 8'd0;
          state_d = FETCH_ST_VALID;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == MaxWait) begin
            err_d   = 1'b1;
            state_d = FETCH_ST_ERR;
          end
        end
      end
      FETCH_ST_VALID: begin
        if (commit) begin
          if (tgt_mis) begin
            mis_d   = 1'b1;
            state_d = FETCH_ST_ERR;
          end else begin
            pc_d    = pc_next;
            state_d = FETCH_ST_FETCH;
          end
        end
      end
      FETCH_ST_ERR: begin
        state_d = FETCH_ST_ERR;
      end
      default: begin
        state_d = FETCH_ST_ERR;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  // Outputs decoded from state and held registers.
  always_comb begin
    mem_req     = (state_q == FETCH_ST_FETCH);
    instr_valid = (state_q == FETCH_ST_VALID);
    mem_addr    = pc_q;
    pc          = pc_q;
    instr       = instr_q;
    fetch_err   = err_q;
    misalign    = mis_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a
// randomized run against an abstract PC/instr model.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          MAXW   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        commit = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] pc_off = 32'd0;
  logic        fetch_err;
  logic        misalign;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mpc;

  instr_fetch #(
    .RESET_PC (RST_PC),
    .MAX_WAIT (MAXW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus_4   (pc_plus_4),
    .commit      (commit),
    .pc_src      (pc_src),
    .pc_off      (pc_off),
    .fetch_err   (fetch_err),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // Hold reset, check reset outputs, release, expect first request.
  task automatic do_reset(input int cyc);
    rst = 1'b1;
    mem_ack = 1'b0;
    commit = 1'b0;
    repeat (cyc) step();
    n_checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ctl: req=%b vld=%b want 0 0",
               mem_req, instr_valid);
    end
    n_checks++;
    if (pc !== RST_PC || instr !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_regs: pc=%h instr=%h want %h 0",
               pc, instr, RST_PC);
    end
    n_checks++;
    if (fetch_err !== 1'b0 || misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags: err=%b mis=%b want 0 0",
               fetch_err, misalign);
    end
    rst = 1'b0;
    mpc = RST_PC;
    step();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL first_req: req=%b addr=%h want 1 %h",
               mem_req, mem_addr, RST_PC);
    end
  endtask

  // Serve the pending fetch after dly wait cycles.
  task automatic fetch_one(input logic [31:0] data,
                           input int dly);
    for (int i = 0; i < dly; i++) begin
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== mpc) begin
        n_fail++;
        $display("FAIL fetch_wait: req=%b addr=%h want 1 %h",
                 mem_req, mem_addr, mpc);
      end
      step();
    end
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== mpc) begin
      n_fail++;
      $display("FAIL fetch_req: req=%b addr=%h want 1 %h",
               mem_req, mem_addr, mpc);
    end
    mem_ack = 1'b1;
    mem_rdata = data;
    step();
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== data ||
        mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_instr: vld=%b req=%b instr=%h want 1 0 %h",
               instr_valid, mem_req, instr, data);
    end
    n_checks++;
    if (pc !== mpc || pc_plus_4 !== mpc + 32'd4) begin
      n_fail++;
      $display("FAIL fetch_pc: pc=%h p4=%h want %h %h",
               pc, pc_plus_4, mpc, mpc + 32'd4);
    end
  endtask

  // Commit in VALID; returns 1 if the target was misaligned.
  task automatic commit_one(input logic src,
                            input logic [31:0] off,
                            output logic bad);
    logic [31:0] tgt;
    tgt = (src == PC_SRC_PLUS_OFF) ? mpc + off : mpc + 32'd4;
    bad = (tgt % 4) != 0;
    commit = 1'b1;
    pc_src = src;
    pc_off = off;
    step();
    commit = 1'b0;
    pc_off = $urandom;
    pc_src = 1'($urandom);
    if (bad) begin
      n_checks++;
      if (misalign !== 1'b1 || pc !== mpc ||
          mem_req !== 1'b0 || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL commit_mis: mis=%b pc=%h req=%b vld=%b want 1 %h 0 0",
                 misalign, pc, mem_req, instr_valid, mpc);
      end
    end else begin
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== tgt ||
          instr_valid !== 1'b0 || misalign !== 1'b0) begin
        n_fail++;
        $display("FAIL commit_go: req=%b addr=%h vld=%b mis=%b want 1 %h 0 0",
                 mem_req, mem_addr, instr_valid, misalign, tgt);
      end
      mpc = tgt;
    end
  endtask

  task automatic test_reset_first_fetch();
    do_reset(2);
    fetch_one(32'hffc4a303, 0);
  endtask

  task automatic test_commit_plus4();
    logic bad;
    commit_one(PC_SRC_PLUS_4, 32'd0, bad);
    fetch_one(32'h0064a423, 2);
    n_checks++;
    if (pc !== 32'h4) begin
      n_fail++;
      $display("FAIL plus4_pc: pc=%h want 4", pc);
    end
  endtask

  task automatic test_branch();
    logic bad;
    commit_one(PC_SRC_PLUS_OFF, 32'hc, bad);
    fetch_one(32'h11111111, 1);
    commit_one(PC_SRC_PLUS_OFF, 32'hfffffff4, bad);
    fetch_one(32'h22222222, 0);
    n_checks++;
    if (pc !== 32'h4) begin
      n_fail++;
      $display("FAIL branch_back: pc=%h want 4", pc);
    end
    do_reset(1);
    fetch_one(32'h33333333, 0);
    commit_one(PC_SRC_PLUS_OFF, 32'hfffffffc, bad);
    fetch_one(32'h44444444, 1);
    n_checks++;
    if (pc !== 32'hfffffffc || fetch_err !== 1'b0 ||
        misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_wrap: pc=%h err=%b mis=%b want fffffffc 0 0",
               pc, fetch_err, misalign);
    end
  endtask

  task automatic test_misalign();
    logic bad;
    do_reset(1);
    fetch_one(32'h55555555, 0);
    commit_one(PC_SRC_PLUS_OFF, 32'h8, bad);
    fetch_one(32'h66666666, 0);
    commit_one(PC_SRC_PLUS_OFF, 32'h2, bad);
    mem_ack = 1'b1;
    commit = 1'b1;
    repeat (5) begin
      step();
      n_checks++;
      if (mem_req !== 1'b0 || misalign !== 1'b1 ||
          pc !== 32'h8 || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mis_hold: req=%b mis=%b pc=%h vld=%b want 0 1 8 0",
                 mem_req, misalign, pc, instr_valid);
      end
    end
    mem_ack = 1'b0;
    commit = 1'b0;
    do_reset(1);
  endtask

  task automatic test_timeout();
    do_reset(1);
    for (int i = 0; i < MAXW; i++) begin
      n_checks++;
      if (mem_req !== 1'b1 || fetch_err !== 1'b0) begin
        n_fail++;
        $display("FAIL to_wait%0d: req=%b err=%b want 1 0",
                 i, mem_req, fetch_err);
      end
      step();
    end
    n_checks++;
    if (fetch_err !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL to_trip: err=%b req=%b want 1 0",
               fetch_err, mem_req);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'hdeadbeef;
    commit = 1'b1;
    repeat (3) step();
    mem_ack = 1'b0;
    commit = 1'b0;
    step();
    n_checks++;
    if (fetch_err !== 1'b1 || mem_req !== 1'b0 ||
        instr_valid !== 1'b0 || pc !== RST_PC) begin
      n_fail++;
      $display("FAIL to_ignore: err=%b req=%b vld=%b pc=%h want 1 0 0 %h",
               fetch_err, mem_req, instr_valid, pc, RST_PC);
    end
    do_reset(1);
  endtask

  task automatic test_reset_mid();
    logic bad;
    fetch_one(32'h77777777, 0);
    commit_one(PC_SRC_PLUS_OFF, 32'h20, bad);
    n_checks++;
    if (mem_addr !== 32'h20) begin
      n_fail++;
      $display("FAIL mid_setup: addr=%h want 20", mem_addr);
    end
    step();
    do_reset(1);
    fetch_one(32'h88888888, 1);
    do_reset(1);
    fetch_one(32'h99999999, 0);
  endtask

  task automatic test_random();
    logic        bad;
    logic        src;
    logic [31:0] off;
    do_reset(1);
    for (int n = 0; n < 60; n++) begin
      fetch_one($urandom, int'($urandom_range(0, MAXW - 1)));
      src = 1'($urandom);
      if ($urandom_range(0, 9) == 0)
        off = {$urandom_range(0, 255), 2'b00} |
              32'($urandom_range(1, 3));
      else
        off = 32'($signed(11'($urandom)) * 4);
      commit_one(src, off, bad);
      if (bad) do_reset(1);
    end
  endtask

  initial begin
    test_reset_first_fetch();
    test_commit_plus4();
    test_branch();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
